viterbi_stage_ctrl: RTL and testbench

Sequencer for the 2-state (00/11) Viterbi add-compare-select (ACS) butterfly datapath. Per trellis stage it:
- accepts one received soft-symbol pair over a valid/ready handshake;
- drives the symbol pair and the current path metrics into the external pipelined ACS stage;
- waits out the ACS latency, then commits the new metrics and survivor decisions.
Keeps register-exchange survivor histories and, after NUM_STAGES stages, reports the winning state and decoded path.

---
 rtl/viterbi_ctrl_pkg.sv | 23 ++
 rtl/viterbi_reg_exchange.sv | 38 +++
 rtl/viterbi_stage_ctrl.sv | 165 ++++++++++++++++
 tb/tb_viterbi_stage_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_ctrl_pkg.sv
// Shared definitions for the Viterbi ACS stage sequencer: FSM states, default
// sizing and the survivor-state encoding.
package viterbi_ctrl_pkg;

  localparam int W_DEF          = 8;
  localparam int NUM_STAGES_DEF = 4;
  localparam int ACS_LAT_DEF    = 3;
  localparam int INIT_PM00      = 0;
  localparam int INIT_PM11_DEF  = 64;

  // Bit shifted into a survivor history when that state is the destination.
  localparam logic ST_00 = 1'b0;
  localparam logic ST_11 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/viterbi_reg_exchange.sv
// Register-exchange survivor memory for the 2-state (00/11) trellis. Each
// enabled cycle copies the chosen predecessor history and appends the state bit.
module viterbi_reg_exchange
  import viterbi_ctrl_pkg::*;
#(
  parameter int N = NUM_STAGES_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         dec_00_i,
  input  logic         dec_11_i,
  output logic [N-1:0] hist_00_o,
  output logic [N-1:0] hist_11_o
);

  logic [N-1:0] hist_00_q, hist_11_q;
  logic [N-1:0] src_00, src_11;

  // Both sources read the pre-update histories, so the swap case is safe.
  assign src_00 = dec_00_i ? hist_11_q : hist_00_q;
  assign src_11 = dec_11_i ? hist_00_q : hist_11_q;

  always_ff @(posedge CLK) begin
    if (!RST_N || clr_i) begin
      hist_00_q <= '0;
      hist_11_q <= '0;
    end else if (en_i) begin
      hist_00_q <= {src_00[N-2:0], ST_00};
      hist_11_q <= {src_11[N-2:0], ST_11};
    end
  end

  assign hist_00_o = hist_00_q;
  assign hist_11_o = hist_11_q;

endmodule

// File: rtl/viterbi_stage_ctrl.sv
// Per-stage sequencer for an external pipelined 2-state ACS butterfly.
// Define PM_NORM_EN to store metrics normalised so the smaller one is zero.
module viterbi_stage_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int ACS_LAT    = ACS_LAT_DEF,
  parameter int INIT_PM11  = INIT_PM11_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  sym_valid,
  input  logic [W-1:0]          sym_r0,
  input  logic [W-1:0]          sym_r1,
  output logic                  sym_ready,
  output logic                  acs_issue,
  output logic [W-1:0]          acs_r0,
  output logic [W-1:0]          acs_r1,
  output logic [W-1:0]          acs_pm00,
  output logic [W-1:0]          acs_pm11,
  input  logic [W-1:0]          acs_end_00,
  input  logic [W-1:0]          acs_end_11,
  input  logic                  acs_dec_00,
  input  logic                  acs_dec_11,
  output logic                  busy,
  output logic                  done,
  output logic                  best_state,
  output logic [NUM_STAGES-1:0] best_path,
  output logic [W-1:0]          pm_00,
  output logic [W-1:0]          pm_11,
  output logic [2:0]            dbg_state
);

  localparam int WC_W = $clog2(ACS_LAT + 1);
  localparam int SC_W = $clog2(NUM_STAGES + 1);

  // Handshake: a symbol pair transfers on a rising edge where sym_valid and
  // sym_ready are both high; sym_ready is registered and high only in LOAD.
  ctrl_state_e state_q, state_d;

  logic                  sym_ready_q, acs_issue_q, done_q, best_state_q;
  logic [W-1:0]          acs_r0_q, acs_r1_q, acs_pm00_q, acs_pm11_q;
  logic [W-1:0]          pm_00_q, pm_11_q;
  logic [NUM_STAGES-1:0] best_path_q;
  logic [WC_W-1:0]       wait_cnt_q;
  logic [SC_W-1:0]       stage_cnt_q;
  logic                  start_fire, load_fire, commit_fire;
  logic [NUM_STAGES-1:0] hist_00, hist_11;
  logic signed [W-1:0]   end_00_s, end_11_s, pm_new_00, pm_new_11;

  assign start_fire  = (state_q == S_IDLE) && start;
  assign load_fire   = (state_q == S_LOAD) && sym_valid && sym_ready_q;
  assign commit_fire = (state_q == S_COMMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   if (sym_valid && sym_ready_q) state_d = S_WAIT;
      S_WAIT:   if (wait_cnt_q == WC_W'(1)) state_d = S_COMMIT;
      S_COMMIT: state_d = (stage_cnt_q == SC_W'(NUM_STAGES - 1)) ? S_DONE : S_LOAD;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign end_00_s = acs_end_00;
  assign end_11_s = acs_end_11;

`ifdef PM_NORM_EN
  logic signed [W-1:0] end_min;
  assign end_min   = (end_11_s < end_00_s) ? end_11_s : end_00_s;
  assign pm_new_00 = end_00_s - end_min;
  assign pm_new_11 = end_11_s - end_min;
`else
  assign pm_new_00 = end_00_s;
  assign pm_new_11 = end_11_s;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sym_ready_q  <= 1'b0;
      acs_issue_q  <= 1'b0;
      done_q       <= 1'b0;
      acs_r0_q     <= '0;
      acs_r1_q     <= '0;
      acs_pm00_q   <= '0;
      acs_pm11_q   <= '0;
      pm_00_q      <= W'(INIT_PM00);
      pm_11_q      <= W'(INIT_PM11);
      wait_cnt_q   <= '0;
      stage_cnt_q  <= '0;
      best_state_q <= 1'b0;
      best_path_q  <= '0;
    end else begin
      sym_ready_q <= (state_d == S_LOAD);
      // Issue lands one cycle after the handshake, while the counter is full.
      acs_issue_q <= (state_q == S_WAIT) && (wait_cnt_q == WC_W'(ACS_LAT));
      done_q      <= (state_q == S_DONE);

      if (start_fire) begin
        pm_00_q      <= W'(INIT_PM00);
        pm_11_q      <= W'(INIT_PM11);
        stage_cnt_q  <= '0;
        best_state_q <= 1'b0;
        best_path_q  <= '0;
      end

      if (load_fire) begin
        acs_r0_q   <= sym_r0;
        acs_r1_q   <= sym_r1;
        acs_pm00_q <= pm_00_q;
        acs_pm11_q <= pm_11_q;
        wait_cnt_q <= WC_W'(ACS_LAT);
      end else if (state_q == S_WAIT) begin
        wait_cnt_q <= wait_cnt_q - WC_W'(1);
      end

      if (commit_fire) begin
        pm_00_q     <= pm_new_00;
        pm_11_q     <= pm_new_11;
        stage_cnt_q <= stage_cnt_q + SC_W'(1);
      end

      if (state_q == S_DONE) begin
        // Strict less-than: a metric tie resolves to state 00.
        best_state_q <= ($signed(pm_11_q) < $signed(pm_00_q)) ? ST_11 : ST_00;
        best_path_q  <= ($signed(pm_11_q) < $signed(pm_00_q)) ? hist_11 : hist_00;
      end
    end
  end

  viterbi_reg_exchange #(.N(NUM_STAGES)) u_rx (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr_i     (start_fire),
    .en_i      (commit_fire),
    .dec_00_i  (acs_dec_00),
    .dec_11_i  (acs_dec_11),
    .hist_00_o (hist_00),
    .hist_11_o (hist_11)
  );

  assign sym_ready  = sym_ready_q;
  assign acs_issue  = acs_issue_q;
  assign acs_r0     = acs_r0_q;
  assign acs_r1     = acs_r1_q;
  assign acs_pm00   = acs_pm00_q;
  assign acs_pm11   = acs_pm11_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign best_state = best_state_q;
  assign best_path  = best_path_q;
  assign pm_00      = pm_00_q;
  assign pm_11      = pm_11_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_viterbi_stage_ctrl.sv
// Bench for viterbi_stage_ctrl: directed vector table, randomized blocks
// against a path-level survivor model, and a mid-block reset sequence.
module tb_viterbi_stage_ctrl;
  import viterbi_ctrl_pkg::*;

  localparam int W = 8, NS = 4, LAT = 3, INIT11 = 64, STG = LAT + 2;

  logic CLK = 1'b0, RST_N = 1'b0, start = 1'b0, sym_valid = 1'b0;
  logic [W-1:0] sym_r0 = '0, sym_r1 = '0;
  logic [W-1:0] acs_end_00 = '0, acs_end_11 = '0;
  logic acs_dec_00 = 1'b0, acs_dec_11 = 1'b0;
  logic sym_ready, acs_issue, busy, done, best_state;
  logic [W-1:0] acs_r0, acs_r1, acs_pm00, acs_pm11, pm_00, pm_11;
  logic [NS-1:0] best_path;
  logic [2:0] dbg_state;

  viterbi_stage_ctrl #(.W(W), .NUM_STAGES(NS), .ACS_LAT(LAT), .INIT_PM11(INIT11)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .sym_valid(sym_valid),
    .sym_r0(sym_r0), .sym_r1(sym_r1), .sym_ready(sym_ready), .acs_issue(acs_issue),
    .acs_r0(acs_r0), .acs_r1(acs_r1), .acs_pm00(acs_pm00), .acs_pm11(acs_pm11),
    .acs_end_00(acs_end_00), .acs_end_11(acs_end_11),
    .acs_dec_00(acs_dec_00), .acs_dec_11(acs_dec_11),
    .busy(busy), .done(done), .best_state(best_state), .best_path(best_path),
    .pm_00(pm_00), .pm_11(pm_11), .dbg_state(dbg_state)
  );

  // ---- clock / cycle counter ----
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---- stimulus tables and reference model ----
  logic signed [W-1:0] r_e00[NS], r_e11[NS];
  logic r_d00[NS], r_d11[NS];
  logic [W-1:0] s_r0[NS], s_r1[NS];
  logic signed [W-1:0] m_pm00, m_pm11;
  logic [NS-1:0] m_h00, m_h11;
  int r_idx, t0;
  int issue_q[$];
  int done_q[$];

  task automatic reset_model();
    m_pm00 = 0; m_pm11 = INIT11; m_h00 = '0; m_h11 = '0; r_idx = 0;
    issue_q.delete(); done_q.delete();
  endtask

  // Survivor paths as integers: new path = predecessor path * 2 + own state bit.
  task automatic model_stage(input int k);
    int src0, src1, lim;
    lim  = 1 << NS;
    src0 = r_d00[k] ? int'(m_h11) : int'(m_h00);
    src1 = r_d11[k] ? int'(m_h00) : int'(m_h11);
    m_h00 = NS'((src0 * 2) % lim);
    m_h11 = NS'((src1 * 2 + 1) % lim);
    m_pm00 = r_e00[k];
    m_pm11 = r_e11[k];
`ifdef PM_NORM_EN
    begin
      logic signed [W-1:0] mn;
      mn = (m_pm00 < m_pm11) ? m_pm00 : m_pm11;
      m_pm00 = m_pm00 - mn;
      m_pm11 = m_pm11 - mn;
    end
`endif
  endtask

  // ACS responder and scoreboard: sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST_N && acs_issue) begin
      issue_q.push_back(cyc - t0);
      if (r_idx < NS) begin
        check("acs_r0", acs_r0, s_r0[r_idx]);
        check("acs_r1", acs_r1, s_r1[r_idx]);
        check("acs_pm00", $signed(acs_pm00), m_pm00);
        check("acs_pm11", $signed(acs_pm11), m_pm11);
        acs_end_00 = r_e00[r_idx];
        acs_end_11 = r_e11[r_idx];
        acs_dec_00 = r_d00[r_idx];
        acs_dec_11 = r_d11[r_idx];
        model_stage(r_idx);
        r_idx++;
      end
    end
    if (RST_N && done) begin
      done_q.push_back(cyc - t0);
      check("best_state", best_state, (m_pm11 < m_pm00) ? 1 : 0);
      check("best_path", best_path, (m_pm11 < m_pm00) ? m_h11 : m_h00);
      check("pm_00", $signed(pm_00), m_pm00);
      check("pm_11", $signed(pm_11), m_pm11);
    end
  end

  // ---- driver tasks ----
  task automatic do_start();
    @(negedge CLK); start = 1'b1;
    @(posedge CLK); #1; t0 = cyc; start = 1'b0;
  endtask

  task automatic feed_stage(input int s, input int stall, input bit kick);
    int guard;
    logic [W-1:0] hold_r0, hold_pm;
    sym_r0 = s_r0[s]; sym_r1 = s_r1[s];
    sym_valid = (stall == 0);
    guard = 0;
    do begin @(negedge CLK); guard++; end while (!sym_ready && guard < 200);
    check("ready_timeout", sym_ready, 1);
    if (stall > 0) begin
      hold_r0 = acs_r0; hold_pm = acs_pm00;
      for (int k = 0; k < stall; k++) begin
        check("bp_ready", sym_ready, 1);
        check("bp_no_issue", acs_issue, 0);
        check("bp_r0_hold", acs_r0, hold_r0);
        check("bp_pm_hold", acs_pm00, hold_pm);
        @(negedge CLK);
      end
      sym_valid = 1'b1;
    end
    @(posedge CLK); #1;
    if (kick) begin
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; start = 1'b0;
      check("busy_kick", busy, 1);
    end
  endtask

  task automatic run_block(input int stall_stage, input int stall_len, input int kick_stage);
    int guard, exp_e;
    reset_model();
    do_start();
    for (int s = 0; s < NS; s++)
      feed_stage(s, (s == stall_stage) ? stall_len : 0, s == kick_stage);
    sym_valid = 1'b0;
    guard = 0;
    while (done_q.size() == 0 && guard < 200) begin @(negedge CLK); guard++; end
    check("done_seen", done_q.size(), 1);
    @(negedge CLK);
    check("done_pulse_1cyc", done, 0);
    check("busy_after_done", busy, 0);
    check("issue_count", issue_q.size(), NS);
    for (int k = 0; k < NS && k < issue_q.size(); k++) begin
      exp_e = 2 + STG * k + ((stall_stage >= 0 && k >= stall_stage) ? stall_len : 0);
      check("issue_edge", issue_q[k], exp_e);
    end
    if (done_q.size() > 0)
      check("done_edge", done_q[0], NS * STG + 1 + ((stall_stage >= 0) ? stall_len : 0));
  endtask

  // ---- directed vector table ----
  typedef struct {
    logic signed [W-1:0] e00, e11;
    logic                d00, d11;
    int                  stall_stage, stall_len, kick_stage;
    logic                exp_best;
    logic [NS-1:0]       exp_path;
    logic signed [W-1:0] exp_pm00, exp_pm11;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int guard;
    //               e00  e11 d00 d11 stl len kick best path     pm00 pm11
    vecs[0] = '{  5,   9, 0, 0, -1, 0, -1, 0, 4'b0000,  5,  9};
    vecs[1] = '{  2,   7, 1, 0, -1, 0, -1, 0, 4'b1110,  2,  7};
    vecs[2] = '{ 20,  -3, 0, 1,  1, 6, -1, 1, 4'b0001, 20, -3};
    vecs[3] = '{ 12,  12, 1, 1, -1, 0,  1, 0, 4'b1010, 12, 12};
    vecs[4] = '{ 40,  25, 0, 0, -1, 0, -1, 1, 4'b1111, 40, 25};
`ifdef PM_NORM_EN
    vecs[0].exp_pm00 = 0;  vecs[0].exp_pm11 = 4;
    vecs[1].exp_pm00 = 0;  vecs[1].exp_pm11 = 5;
    vecs[2].exp_pm00 = 23; vecs[2].exp_pm11 = 0;
    vecs[3].exp_pm00 = 0;  vecs[3].exp_pm11 = 0;
    vecs[4].exp_pm00 = 15; vecs[4].exp_pm11 = 0;
`endif

    // ---- reset with start held high ----
    RST_N = 1'b0; start = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_done", done, 0);
    check("rst_acs_issue", acs_issue, 0);
    check("rst_pm_00", pm_00, 0);
    check("rst_pm_11", pm_11, INIT11);
    check("rst_state_idle", dbg_state, S_IDLE);
    @(negedge CLK); start = 1'b0; RST_N = 1'b1;

    // ---- directed vectors ----
    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < NS; s++) begin
        r_e00[s] = vecs[v].e00; r_e11[s] = vecs[v].e11;
        r_d00[s] = vecs[v].d00; r_d11[s] = vecs[v].d11;
        s_r0[s] = W'($urandom_range(0, 255)); s_r1[s] = W'($urandom_range(0, 255));
      end
      run_block(vecs[v].stall_stage, vecs[v].stall_len, vecs[v].kick_stage);
      check("vec_best_state", best_state, vecs[v].exp_best);
      check("vec_best_path", best_path, vecs[v].exp_path);
      check("vec_pm_00", $signed(pm_00), vecs[v].exp_pm00);
      check("vec_pm_11", $signed(pm_11), vecs[v].exp_pm11);
    end

    // ---- randomized blocks ----
    for (int b = 0; b < 8; b++) begin
      for (int s = 0; s < NS; s++) begin
        r_e00[s] = W'(int'($urandom_range(0, 120)) - 60);
        r_e11[s] = W'(int'($urandom_range(0, 120)) - 60);
        r_d00[s] = 1'($urandom_range(0, 1));
        r_d11[s] = 1'($urandom_range(0, 1));
        s_r0[s] = W'($urandom_range(0, 255)); s_r1[s] = W'($urandom_range(0, 255));
      end
      run_block(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 5)), -1);
    end

    // ---- reset during COMMIT of the third stage ----
    for (int s = 0; s < NS; s++) begin
      r_e00[s] = 30; r_e11[s] = 10; r_d00[s] = 1'b1; r_d11[s] = 1'b0;
      s_r0[s] = W'($urandom_range(0, 255)); s_r1[s] = W'($urandom_range(0, 255));
    end
    reset_model();
    do_start();
    for (int s = 0; s < 3; s++) feed_stage(s, 0, 1'b0);
    sym_valid = 1'b0;
    guard = 0;
    do begin @(negedge CLK); guard++; end while (dbg_state != S_COMMIT && guard < 50);
    check("abort_reach_commit", dbg_state, S_COMMIT);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_pm_00", pm_00, 0);
    check("abort_pm_11", pm_11, INIT11);
    check("abort_acs_r0", acs_r0, 0);
    repeat (30) @(negedge CLK);
    check("abort_no_done", done_q.size(), 0);
    check("abort_idle", dbg_state, S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
